// File: rtl/mips_multicycle_cpu.sv
// Multi-cycle MIPS core: one instruction at a time through FETCH/DECODE/EXEC/MEM/WB,
// with req/ack handshakes so the instruction and data memories may stall the core.
module mips_multicycle_cpu #(
   parameter int ADDR_W   = 10,
   parameter int RESET_PC = 0,
   parameter int CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [31:0]       dmem_addr,
   output logic [31:0]       dmem_wdata,
   input  logic              dmem_ack,
   input  logic [31:0]       dmem_rdata,
   output logic [ADDR_W-1:0] pc,
   output logic              halted,
   output logic              illegal,
   output logic [CNT_W-1:0]  retired_count
);
   // FETCH|wait imem  DECODE|read regs  EXEC|ALU  MEM|wait dmem  WB|commit  HALTED/TRAP|stopped
   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED, S_TRAP} state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_BEQ  = 6'h04, OP_BNE = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B, OP_HALT = 6'h3F;
   localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_ADD = 6'h20, F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24, F_OR  = 6'h25, F_SLT = 6'h2A;

   state_t      state, state_next;
   logic [31:0] ir, a, b, simm, zimm, alu_out, mdr, alu_res, wr_data;
   logic [31:0] regs [32];
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, shamt, wr_addr;
   logic        legal, is_mem, wr_en;
   logic [ADDR_W-1:0] pc_next;

   assign op    = ir[31:26];
   assign rs    = ir[25:21];
   assign rt    = ir[20:16];
   assign rd    = ir[15:11];
   assign shamt = ir[10:6];
   assign funct = ir[5:0];
   assign is_mem = (op == OP_LW) || (op == OP_SW);

   always_comb begin
      legal = 1'b0;
      case (op)
         OP_RTYPE: legal = funct inside {F_SLL, F_SRL, F_ADD, F_SUB, F_AND, F_OR, F_SLT};
         OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_HALT: legal = 1'b1;
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      alu_res = a + simm;
      case (op)
         OP_RTYPE:
            case (funct)
               F_SUB:   alu_res = a - b;
               F_AND:   alu_res = a & b;
               F_OR:    alu_res = a | b;
               F_SLT:   alu_res = {31'd0, $signed(a) < $signed(b)};
               F_SLL:   alu_res = b << shamt;
               F_SRL:   alu_res = b >> shamt;
               default: alu_res = a + b;
            endcase
         OP_ANDI: alu_res = a & zimm;
         OP_ORI:  alu_res = a | zimm;
         default: alu_res = a + simm;
      endcase
   end

   always_comb begin
      pc_next = pc + ADDR_W'(1);
      wr_en   = 1'b0;
      wr_addr = rt;
      wr_data = alu_out;
      case (op)
         OP_RTYPE: begin
            wr_en   = 1'b1;
            wr_addr = rd;
         end
         OP_ADDI, OP_ANDI, OP_ORI: wr_en = 1'b1;
         OP_LW: begin
            wr_en   = 1'b1;
            wr_data = mdr;
         end
         OP_BEQ: if (a == b) pc_next = pc + ADDR_W'(1) + simm[ADDR_W-1:0];
         OP_BNE: if (a != b) pc_next = pc + ADDR_W'(1) + simm[ADDR_W-1:0];
         OP_J:   pc_next = ir[ADDR_W-1:0];
         default: ;
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         S_FETCH:  if (imem_ack) state_next = S_DECODE;
         S_DECODE: state_next = legal ? S_EXEC : S_TRAP;
         S_EXEC: begin
            if (op == OP_HALT)     state_next = S_HALTED;
            else if (!is_mem)      state_next = S_WB;
            else if (alu_res[1:0] != 2'b00) state_next = S_TRAP;
            else                   state_next = S_MEM;
         end
         S_MEM:    if (dmem_ack) state_next = S_WB;
         S_WB:     state_next = S_FETCH;
         default:  state_next = state;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_FETCH;
      else     state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc            <= ADDR_W'(RESET_PC);
         ir            <= '0;
         a             <= '0;
         b             <= '0;
         simm          <= '0;
         zimm          <= '0;
         alu_out       <= '0;
         mdr           <= '0;
         retired_count <= '0;
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else begin
         case (state)
            S_FETCH: if (imem_ack) ir <= imem_rdata;
            S_DECODE: begin
               a    <= regs[rs];
               b    <= regs[rt];
               simm <= {{16{ir[15]}}, ir[15:0]};
               zimm <= {16'd0, ir[15:0]};
            end
            S_EXEC: alu_out <= alu_res;
            S_MEM:  if (dmem_ack && op == OP_LW) mdr <= dmem_rdata;
            S_WB: begin
               pc            <= pc_next;
               retired_count <= retired_count + CNT_W'(1);
               // $0 is never written, so it reads back as zero forever
               if (wr_en && wr_addr != 5'd0) regs[wr_addr] <= wr_data;
            end
            default: ;
         endcase
      end
   end

   assign imem_req   = (state == S_FETCH) && !rst;
   assign imem_addr  = pc;
   assign dmem_req   = (state == S_MEM) && !rst;
   assign dmem_we    = dmem_req && (op == OP_SW);
   assign dmem_addr  = dmem_req ? alu_out : '0;
   assign dmem_wdata = dmem_req ? b : '0;
   assign halted     = (state == S_HALTED) || (state == S_TRAP);
   assign illegal    = (state == S_TRAP);
endmodule

// File: tb/tb_mips_multicycle_cpu.sv
// Bench for mips_multicycle_cpu: directed programs, wait-state memories and an
// instruction-level reference model compared against the core every cycle.
module tb_mips_multicycle_cpu;
   localparam int AW = 4;
   localparam logic [31:0] HALT = 32'hFC00_0000;
   localparam int A_RETIRE = 0, A_MEM = 1, A_HALT = 2, A_TRAP = 3;
   localparam int M_FETCH = 0, M_WAIT = 1, M_MEM = 2, M_STOP = 3;

   logic clk, rst;
   logic imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted, illegal;
   logic [AW-1:0] imem_addr, pc;
   logic [31:0] imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, retired_count;

   mips_multicycle_cpu #(.ADDR_W(AW), .RESET_PC(0), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .pc(pc), .halted(halted), .illegal(illegal), .retired_count(retired_count)
   );

   int errors = 0, checks = 0;
   logic [31:0] imem [16];
   logic [31:0] mem_d [64];
   logic [31:0] m_dmem [64];
   logic [31:0] prog [$];
   int imem_wait = 0, dmem_wait = 0, dack_force = 0, icnt = 0, dcnt = 0;

   // reference model state
   logic [31:0] m_regs [32];
   logic [AW-1:0] m_pc;
   logic [31:0] m_ir, m_ret, m_maddr;
   logic m_halt, m_ill;
   int mode, m_cnt, m_act, cyc, halt_cyc, ret_edge [16];
   logic dreq_seen, st_cap;
   logic [31:0] st_addr, st_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] sh);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction
   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // memories: ack after a configurable number of wait cycles
   initial begin
      imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0; dmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (imem_req) begin
            imem_rdata = imem[imem_addr];
            imem_ack   = (icnt == imem_wait);
            icnt++;
         end else begin
            icnt = 0; imem_ack = 1'b0;
         end
         if (dack_force > 0) begin
            dmem_ack = 1'b1; dack_force--;
         end else if (dmem_req) begin
            dmem_rdata = mem_d[dmem_addr[7:2]];
            dmem_ack   = (dcnt == dmem_wait);
            dcnt++;
            if (dmem_ack && dmem_we) mem_d[dmem_addr[7:2]] = dmem_wdata;
         end else begin
            dcnt = 0; dmem_ack = 1'b0;
         end
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      for (int i = 0; i < 16; i++) ret_edge[i] = 0;
      m_pc = '0; m_ret = '0; m_halt = 1'b0; m_ill = 1'b0; mode = M_FETCH;
      cyc = 0; halt_cyc = 0; dreq_seen = 1'b0; st_cap = 1'b0;
   endtask

   task automatic model_classify();
      logic [5:0] op, fn;
      logic ok;
      op = m_ir[31:26]; fn = m_ir[5:0];
      ok = (op == 6'h00 && fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02}) ||
           (op inside {6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02});
      mode = M_WAIT;
      if (op == 6'h3F) begin
         m_cnt = 2; m_act = A_HALT;
      end else if (!ok) begin
         m_cnt = 1; m_act = A_TRAP;
      end else if (op == 6'h23 || op == 6'h2B) begin
         m_maddr = m_regs[m_ir[25:21]] + {{16{m_ir[15]}}, m_ir[15:0]};
         m_cnt = 2; m_act = (m_maddr[1:0] != 2'b00) ? A_TRAP : A_MEM;
      end else begin
         m_cnt = 3; m_act = A_RETIRE;
      end
   endtask

   task automatic model_retire();
      logic [5:0] op;
      logic [31:0] a, b, simm, zimm, res;
      logic [4:0] dst;
      logic [AW-1:0] npc;
      op = m_ir[31:26];
      a = m_regs[m_ir[25:21]]; b = m_regs[m_ir[20:16]];
      simm = {{16{m_ir[15]}}, m_ir[15:0]}; zimm = {16'd0, m_ir[15:0]};
      npc = m_pc + AW'(1); res = '0; dst = 5'd0;
      case (op)
         6'h00: begin
            dst = m_ir[15:11];
            case (m_ir[5:0])
               6'h20: res = a + b;
               6'h22: res = a - b;
               6'h24: res = a & b;
               6'h25: res = a | b;
               6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               6'h00: res = b << m_ir[10:6];
               default: res = b >> m_ir[10:6];
            endcase
         end
         6'h08: begin dst = m_ir[20:16]; res = a + simm; end
         6'h0C: begin dst = m_ir[20:16]; res = a & zimm; end
         6'h0D: begin dst = m_ir[20:16]; res = a | zimm; end
         6'h23: begin dst = m_ir[20:16]; res = m_dmem[m_maddr[7:2]]; end
         6'h2B: m_dmem[m_maddr[7:2]] = b;
         6'h04: if (a == b) npc = m_pc + AW'(1) + m_ir[AW-1:0];
         6'h05: if (a != b) npc = m_pc + AW'(1) + m_ir[AW-1:0];
         default: npc = m_ir[AW-1:0];
      endcase
      if (dst != 5'd0) m_regs[dst] = res;
      m_pc = npc;
      m_ret = m_ret + 1;
   endtask

   // compare process: advance the model one clock, then check every output
   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         #1;
         if (rst) model_reset();
         else begin
            cyc++;
            case (mode)
               M_FETCH: if (imem_ack) begin
                  m_ir = imem[m_pc];
                  model_classify();
               end
               M_WAIT: begin
                  m_cnt--;
                  if (m_cnt == 0) begin
                     case (m_act)
                        A_RETIRE: begin model_retire(); mode = M_FETCH; end
                        A_MEM:    mode = M_MEM;
                        A_HALT:   begin m_halt = 1'b1; mode = M_STOP; end
                        default:  begin m_halt = 1'b1; m_ill = 1'b1; mode = M_STOP; end
                     endcase
                  end
               end
               M_MEM: if (dmem_ack) begin mode = M_WAIT; m_cnt = 1; m_act = A_RETIRE; end
               default: ;
            endcase
         end
         chk("imem_req", imem_req, mode == M_FETCH && !rst);
         if (imem_req) chk("imem_addr", imem_addr, m_pc);
         chk("dmem_req", dmem_req, mode == M_MEM);
         if (mode == M_MEM) begin
            chk("dmem_we", dmem_we, m_ir[31:26] == 6'h2B);
            chk("dmem_addr", dmem_addr, m_maddr);
            if (m_ir[31:26] == 6'h2B) chk("dmem_wdata", dmem_wdata, m_regs[m_ir[20:16]]);
         end
         if (rst) begin
            chk("rst_dmem_addr", dmem_addr, 0);
            chk("rst_dmem_wdata", dmem_wdata, 0);
            chk("rst_dmem_we", dmem_we, 0);
         end
         chk("pc", pc, m_pc);
         chk("halted", halted, m_halt);
         chk("illegal", illegal, m_ill);
         chk("retired_count", retired_count, m_ret);
         if (dmem_req) dreq_seen = 1'b1;
         if (dmem_req && dmem_we && !st_cap) begin
            st_cap = 1'b1; st_addr = dmem_addr; st_data = dmem_wdata;
         end
         if (halted && halt_cyc == 0) halt_cyc = cyc + 1;
         if (!rst && retired_count < 16 && retired_count != 0 && ret_edge[retired_count] == 0)
            ret_edge[retired_count] = cyc;
      end
   end

   task automatic start_prog(input int iw, input int dw);
      for (int i = 0; i < 16; i++) imem[i] = HALT;
      for (int i = 0; i < prog.size(); i++) imem[i] = prog[i];
      for (int i = 0; i < 64; i++) begin
         mem_d[i] = 32'hA5A5_A5A5; m_dmem[i] = 32'hA5A5_A5A5;
      end
      imem_wait = iw; dmem_wait = dw;
      @(posedge clk); #2 rst = 1'b1;
      @(posedge clk); #2 rst = 1'b0;
   endtask

   task automatic run_to_halt(input string name);
      int n = 0;
      while (!halted && n < 2000) begin
         @(posedge clk); #2;
         n++;
      end
      chk({name, "_reached_halt"}, halted, 1);
   endtask

   initial begin
      rst = 1'b1;
      // 1: basic ALU program, zero-wait
      prog = '{enc_i(6'h08, 5'd0, 5'd1, 16'd5), enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD),
               enc_r(6'h20, 5'd3, 5'd1, 5'd2, 5'd0), HALT};
      start_prog(0, 0);
      run_to_halt("t1");
      chk("t1_halt_cycle", halt_cyc, 16);
      chk("t1_retired", retired_count, 3);
      chk("t1_pc", pc, 3);
      chk("t1_illegal", illegal, 0);
      chk("t1_model_r3", m_regs[3], 2);

      // 2: store/load with 3 data wait cycles
      prog = '{enc_i(6'h08, 5'd0, 5'd1, 16'd5), enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD),
               enc_r(6'h20, 5'd3, 5'd1, 5'd2, 5'd0), enc_i(6'h2B, 5'd0, 5'd3, 16'd8),
               enc_i(6'h23, 5'd0, 5'd4, 16'd8), enc_i(6'h2B, 5'd0, 5'd4, 16'd12), HALT};
      start_prog(0, 3);
      run_to_halt("t2");
      chk("t2_store_addr", st_addr, 8);
      chk("t2_store_data", st_data, 2);
      chk("t2_sw_cycles", ret_edge[4] - ret_edge[3], 8);
      chk("t2_lw_cycles", ret_edge[5] - ret_edge[4], 8);
      chk("t2_mem8", mem_d[2], 2);
      chk("t2_mem12_r4", mem_d[3], 2);

      // 3: branch to self, not-taken bne, wrapping beq
      prog = '{enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF)};
      start_prog(0, 0);
      repeat (40) @(posedge clk);
      #2;
      chk("t3a_pc", pc, 0);
      chk("t3a_retired", retired_count, 10);
      chk("t3a_halted", halted, 0);
      prog = '{enc_i(6'h05, 5'd1, 5'd1, 16'd5)};
      start_prog(0, 0);
      run_to_halt("t3b");
      chk("t3b_pc", pc, 1);
      prog = '{{6'h02, 26'd2}, HALT, enc_i(6'h04, 5'd0, 5'd0, 16'd14)};
      start_prog(1, 0);
      run_to_halt("t3c");
      chk("t3c_pc_wrap", pc, 1);
      chk("t3c_retired", retired_count, 2);

      // 4: $0 writes, slt, shifts
      prog = '{enc_i(6'h08, 5'd0, 5'd0, 16'd7), enc_r(6'h20, 5'd5, 5'd0, 5'd0, 5'd0),
               enc_i(6'h2B, 5'd0, 5'd5, 16'd0), enc_i(6'h08, 5'd0, 5'd1, 16'd5),
               enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD), enc_r(6'h2A, 5'd6, 5'd2, 5'd1, 5'd0),
               enc_i(6'h2B, 5'd0, 5'd6, 16'd4), enc_i(6'h08, 5'd0, 5'd7, 16'd1),
               enc_r(6'h00, 5'd7, 5'd0, 5'd7, 5'd31), enc_r(6'h02, 5'd8, 5'd0, 5'd7, 5'd31),
               enc_i(6'h2B, 5'd0, 5'd8, 16'd8), HALT};
      start_prog(0, 1);
      run_to_halt("t4");
      chk("t4_r5_zero", mem_d[0], 0);
      chk("t4_slt", mem_d[1], 1);
      chk("t4_srl", mem_d[2], 1);
      chk("t4_retired", retired_count, 11);

      // 4b: logic ops with zero-extended immediates, fetch wait states
      prog = '{enc_i(6'h08, 5'd0, 5'd1, 16'hFFFF), enc_i(6'h0C, 5'd1, 5'd2, 16'h8001),
               enc_i(6'h0D, 5'd0, 5'd3, 16'hF0F0), enc_r(6'h22, 5'd4, 5'd3, 5'd2, 5'd0),
               enc_r(6'h24, 5'd5, 5'd1, 5'd3, 5'd0), enc_r(6'h25, 5'd6, 5'd2, 5'd3, 5'd0),
               enc_i(6'h2B, 5'd0, 5'd4, 16'd0), enc_i(6'h2B, 5'd0, 5'd5, 16'd4),
               enc_i(6'h2B, 5'd0, 5'd6, 16'd8), HALT};
      start_prog(2, 0);
      run_to_halt("t4b");
      chk("t4b_sub", mem_d[0], 32'h0000_70EF);
      chk("t4b_and", mem_d[1], 32'h0000_F0F0);
      chk("t4b_or", mem_d[2], 32'h0000_F0F1);

      // 5: unknown opcode, misaligned load, unknown funct
      prog = '{enc_i(6'h08, 5'd0, 5'd1, 16'd1), enc_i(6'h08, 5'd0, 5'd2, 16'd2), 32'hF800_0000};
      start_prog(0, 0);
      run_to_halt("t5");
      repeat (5) @(posedge clk);
      #2;
      chk("t5_pc", pc, 2);
      chk("t5_illegal", illegal, 1);
      chk("t5_retired", retired_count, 2);
      prog = '{enc_i(6'h08, 5'd0, 5'd1, 16'd2), enc_i(6'h23, 5'd1, 5'd2, 16'd4)};
      start_prog(0, 0);
      run_to_halt("t5b");
      chk("t5b_no_dmem_req", dreq_seen, 0);
      chk("t5b_illegal", illegal, 1);
      chk("t5b_pc", pc, 1);
      prog = '{enc_r(6'h21, 5'd3, 5'd1, 5'd2, 5'd0)};
      start_prog(0, 0);
      run_to_halt("t5c");
      chk("t5c_illegal", illegal, 1);
      chk("t5c_retired", retired_count, 0);

      // 6: reset during a data wait, then a stray data ack
      prog = '{enc_i(6'h08, 5'd0, 5'd1, 16'd9), enc_i(6'h2B, 5'd0, 5'd1, 16'd16), HALT};
      start_prog(0, 5);
      begin
         int n = 0;
         while (!dmem_req && n < 50) begin
            @(posedge clk); #2;
            n++;
         end
      end
      chk("t6_reached_mem", dmem_req, 1);
      @(posedge clk); #2 rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0; dack_force = 3; dmem_wait = 0;
      #1;
      chk("t6_dreq_dropped", dmem_req, 0);
      chk("t6_pc_reset", pc, 0);
      chk("t6_refetch_req", imem_req, 1);
      run_to_halt("t6");
      chk("t6_store", mem_d[4], 9);
      chk("t6_retired", retired_count, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
